alu_guard_sequencer: RTL and testbench

- Initiator side of the protected ALU datapath; the ALU, detector and mitigator are the responder.
- Accepts operation requests over valid/ready and drives a, b and opcode into the ALU.
- Samples the ALU result and detection flag, and checks the result against an internal golden model.
- Retries on mismatch, substitutes the golden value when retries are exhausted, then locks out new requests for a fixed period.

---
 rtl/alu_guard_sequencer_pkg.sv | 19 +
 rtl/alu_golden_model.sv | 24 ++
 rtl/alu_guard_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_guard_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_guard_sequencer_pkg.sv
// rtl/alu_guard_sequencer_pkg.sv - shared opcodes, FSM states and width default for the ALU guard sequencer
package alu_guard_sequencer_pkg;

    localparam int WIDTH_DEFAULT = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CHECK,
        ST_RESPOND,
        ST_LOCKOUT
    } state_t;

endpackage

// File: rtl/alu_golden_model.sv
// rtl/alu_golden_model.sv - combinational reference result for the protected ALU
module alu_golden_model
    import alu_guard_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_guard_sequencer.sv
// rtl/alu_guard_sequencer.sv - issues requests to the ALU, checks against golden, retries and substitutes
module alu_guard_sequencer
    import alu_guard_sequencer_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEFAULT,
    parameter int MAX_RETRY      = 2,
    parameter int LOCKOUT_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_alarm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_error,
    output logic [1:0]       rsp_retries,
    output logic             lockout,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] false_alarm_count
);

    localparam int         LCK_W   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [1:0] MAX_R   = 2'(MAX_RETRY);
    localparam logic [LCK_W-1:0] LCK_LOAD = LCK_W'(LOCKOUT_CYCLES - 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [1:0]         op_q;
    logic [1:0]         retry_q;
    logic [LCK_W-1:0]   lock_cnt;
    logic [WIDTH-1:0]   golden;
    logic               mismatch;

    // Latched operands feed the ALU directly so they hold steady across retries.
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_opcode  = op_q;
    assign rsp_retries = retry_q;

    alu_golden_model #(.WIDTH(WIDTH)) u_golden (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (golden)
    );

    assign mismatch = (alu_result != golden);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (req_valid) state_nxt = ST_ISSUE;
            ST_ISSUE:   state_nxt = ST_CHECK;
            ST_CHECK:   state_nxt = (mismatch && (retry_q < MAX_R)) ? ST_ISSUE : ST_RESPOND;
            ST_RESPOND: if (rsp_ready) state_nxt = rsp_error ? ST_LOCKOUT : ST_IDLE;
            ST_LOCKOUT: if (lock_cnt == '0) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESPOND);
        lockout   = (state == ST_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q               <= '0;
            b_q               <= '0;
            op_q              <= '0;
            retry_q           <= '0;
            rsp_result        <= '0;
            rsp_error         <= 1'b0;
            mismatch_count    <= '0;
            false_alarm_count <= '0;
            lock_cnt          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_q     <= req_a;
                        b_q     <= req_b;
                        op_q    <= req_op;
                        retry_q <= '0;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (mismatch_count != '1) mismatch_count <= mismatch_count + 1'b1;
                        if (retry_q < MAX_R) begin
                            retry_q <= retry_q + 2'd1;
                        end else begin
                            rsp_result <= golden;
                            rsp_error  <= 1'b1;
                        end
                    end else begin
                        rsp_result <= alu_result;
                        rsp_error  <= 1'b0;
                        // An alarm on a correct result is counted but never escalated.
                        if (alu_alarm && (false_alarm_count != '1))
                            false_alarm_count <= false_alarm_count + 1'b1;
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready && rsp_error) lock_cnt <= LCK_LOAD;
                end
                ST_LOCKOUT: begin
                    if (lock_cnt != '0) lock_cnt <= lock_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_guard_sequencer.sv
// tb/tb_alu_guard_sequencer.sv - scoreboard bench for alu_guard_sequencer
module tb_alu_guard_sequencer;

    typedef struct {
        logic [3:0] result;
        logic       error;
        logic [1:0] retries;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, req_valid, req_ready, rsp_ready, rsp_valid, rsp_error, lockout, alu_alarm;
    logic [3:0] req_a, req_b, alu_a, alu_b, alu_result, rsp_result;
    logic [1:0] req_op, alu_opcode, rsp_retries;
    logic [7:0] mismatch_count, false_alarm_count;
    logic       force_zero, alarm_mode;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_guard_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_alarm(alu_alarm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .rsp_retries(rsp_retries),
        .lockout(lockout), .mismatch_count(mismatch_count), .false_alarm_count(false_alarm_count)
    );

    // Responder-side ALU stand-in with a stuck-at-zero fault mode.
    always_comb begin
        alu_result = 4'd0;
        if (!force_zero) begin
            case (alu_opcode)
                2'b00:   alu_result = alu_a + alu_b;
                2'b01:   alu_result = alu_a - alu_b;
                2'b10:   alu_result = alu_a & alu_b;
                default: alu_result = alu_a ^ alu_b;
            endcase
        end
        alu_alarm = alarm_mode;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Response monitor: a handshake happens at the next edge when valid&ready are seen here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_result", int'(rsp_result), int'(e.result));
                    chk("rsp_error", int'(rsp_error), int'(e.error));
                    chk("rsp_retries", int'(rsp_retries), int'(e.retries));
                end
            end
        end
    end

    task automatic do_req(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int n = 0;
        @(posedge clk); #1;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("req_accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(input int exp_rise);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_latency", n + 1, exp_rise);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(rsp_valid && rsp_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rsp_handshake_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       input logic [3:0] r, input logic err, input logic [1:0] ret);
        exp_q.push_back('{result: r, error: err, retries: ret});
        do_req(a, b, op);
        wait_valid(3 + 2 * int'(ret));
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [3:0] snap_res;
        logic       snap_err;
        logic [1:0] snap_ret;

        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        rsp_ready = 1'b1; force_zero = 1'b0; alarm_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_req_ready", int'(req_ready), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_alu_a", int'(alu_a), 0);
        chk("reset_alu_b", int'(alu_b), 0);
        chk("reset_alu_opcode", int'(alu_opcode), 0);
        chk("reset_rsp_result", int'(rsp_result), 0);
        chk("reset_lockout", int'(lockout), 0);
        chk("reset_mismatch_count", int'(mismatch_count), 0);

        run(4'd3, 4'd4, 2'b00, 4'd7, 1'b0, 2'd0);
        chk("alu_a_held", int'(alu_a), 3);
        run(4'd12, 4'd5, 2'b00, 4'd1, 1'b0, 2'd0);
        run(4'd2, 4'd5, 2'b01, 4'd13, 1'b0, 2'd0);

        force_zero = 1'b1;
        run(4'b1010, 4'b0101, 2'b11, 4'b1111, 1'b1, 2'd2);
        force_zero = 1'b0;
        chk("mismatch_count", int'(mismatch_count), 3);
        for (int i = 0; i < 8; i++) begin
            chk("lockout_active", int'(lockout), 1);
            chk("lockout_req_ready", int'(req_ready), 0);
            @(posedge clk); #1;
        end
        chk("lockout_released", int'(lockout), 0);
        chk("lockout_req_ready_back", int'(req_ready), 1);

        alarm_mode = 1'b1;
        run(4'd3, 4'd13, 2'b00, 4'd0, 1'b0, 2'd0);
        alarm_mode = 1'b0;
        chk("false_alarm_count", int'(false_alarm_count), 1);
        chk("mismatch_count_kept", int'(mismatch_count), 3);

        rsp_ready = 1'b0;
        exp_q.push_back('{result: 4'd2, error: 1'b0, retries: 2'd0});
        do_req(4'd6, 4'd3, 2'b10);
        wait_valid(3);
        snap_res = rsp_result; snap_err = rsp_error; snap_ret = rsp_retries;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", int'(rsp_valid), 1);
            chk("bp_stable", int'({rsp_result, rsp_error, rsp_retries}),
                int'({snap_res, snap_err, snap_ret}));
        end
        rsp_ready = 1'b1;
        wait_done();
        chk("bp_accepted", int'(rsp_valid), 0);

        do_req(4'd1, 4'd1, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_req_ready", int'(req_ready), 1);
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        chk("midrst_alu_a", int'(alu_a), 0);
        chk("midrst_alu_b", int'(alu_b), 0);
        chk("midrst_rsp_result", int'(rsp_result), 0);
        chk("midrst_mismatch_count", int'(mismatch_count), 0);
        chk("midrst_false_alarm_count", int'(false_alarm_count), 0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("midrst_no_response", int'(rsp_valid), 0);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
